// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects the write-back value, commits it, and serves two bypassed async read ports.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [DATA_W-1:0] ReadData_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [ADDR_W-1:0] WriteAddr_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBData_o,
    output logic              WBValid_o,
    output logic [CNT_W-1:0]  WBCount_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  wb_count;
    logic              wb_valid;

    always_comb begin
        WBData_o = MemToReg_i ? ReadData_i : ALUResult_i;
    end

    // Gated by RegWrite first so an X MemToReg on a bubble never reaches valid.
    always_comb begin
        wb_valid = 1'b0;
        if (RegWrite_i == 1'b1 && WriteAddr_i != '0) begin
            wb_valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (wb_valid) begin
            regs[WriteAddr_i] <= WBData_o;
            wb_count          <= wb_count + 1'b1;
        end
    end

    // Register 0 reads as zero; bypass only while out of reset.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = (addr == '0) ? '0 : regs[addr];
        if (rst_i && wb_valid && addr == WriteAddr_i) begin
            val = WBData_o;
        end
        return val;
    endfunction

    always_comb begin
        RSdata_o = read_port(RSaddr_i);
        RTdata_o = read_port(RTaddr_i);
    end

    assign WBValid_o = wb_valid;
    assign WBCount_o = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: table of single-cycle vectors plus hand-written
// sequences for counter wrap and reset with a concurrent write.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rw  = 1'b0;
    logic        m2r = 1'b0;
    logic [31:0] rd  = '0;
    logic [31:0] alu = '0;
    logic [4:0]  wa  = '0;
    logic [4:0]  rsa = '0;
    logic [4:0]  rta = '0;
    logic [31:0] rs_d, rt_d, wb_d;
    logic        wb_v;
    logic [31:0] cnt;
    logic [31:0] rs_s, rt_s, wb_s;
    logic        wb_vs;
    logic [3:0]  cnt_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk_i(clk), .rst_i(rst), .RegWrite_i(rw), .MemToReg_i(m2r),
        .ReadData_i(rd), .ALUResult_i(alu), .WriteAddr_i(wa),
        .RSaddr_i(rsa), .RTaddr_i(rta), .RSdata_o(rs_d), .RTdata_o(rt_d),
        .WBData_o(wb_d), .WBValid_o(wb_v), .WBCount_o(cnt)
    );

    // Narrow-counter instance on the same inputs so the wrap is reachable.
    wb_regfile #(.CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .RegWrite_i(rw), .MemToReg_i(m2r),
        .ReadData_i(rd), .ALUResult_i(alu), .WriteAddr_i(wa),
        .RSaddr_i(rsa), .RTaddr_i(rta), .RSdata_o(rs_s), .RTdata_o(rt_s),
        .WBData_o(wb_s), .WBValid_o(wb_vs), .WBCount_o(cnt_s)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [31:0] exp_wb;
        logic        exp_valid;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
        rw = 1'b1; m2r = 1'b0; alu = v; wa = a;
        tick();
        exp_cnt++;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0,
                    32'h0000_1234, 1'b1, 32'h0000_1234, 32'h0, 1};
        vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd9, 5'd5, 5'd9,
                    32'hDEAD_BEEF, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9,
                    32'h0, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 2};
        vecs[3] = '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0,
                    32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 2};
        vecs[4] = '{1'b0, 1'bx, 32'h0, 32'h77, 5'd5, 5'd5, 5'd0,
                    32'h0, 1'b0, 32'h0000_1234, 32'h0, 2};
        vecs[5] = '{1'b1, 1'b0, 32'h0, 32'hAAAA_5555, 5'd31, 5'd31, 5'd31,
                    32'hAAAA_5555, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555, 3};
        vecs[6] = '{1'b1, 1'b1, 32'h42, 32'h0, 5'd5, 5'd5, 5'd31,
                    32'h42, 1'b1, 32'h42, 32'hAAAA_5555, 4};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9,
                    32'h0, 1'b0, 32'h42, 32'hDEAD_BEEF, 4};
        vecs[8] = '{1'b1, 1'b0, 32'h0, 32'h1, 5'd1, 5'd2, 5'd1,
                    32'h1, 1'b1, 32'h0, 32'h1, 5};

        // Two reset edges, then every address reads zero.
        tick();
        tick();
        rst = 1'b1;
        check("reset_cnt", cnt, 0);
        check("reset_cnt_small", cnt_s, 0);
        for (int i = 0; i < 32; i++) begin
            rsa = 5'(i);
            rta = 5'(31 - i);
            #1;
            check("reset_rs", rs_d, 0);
            check("reset_rt", rt_d, 0);
        end

        for (int i = 0; i < 9; i++) begin
            rw = vecs[i].rw; m2r = vecs[i].m2r; rd = vecs[i].rd; alu = vecs[i].alu;
            wa = vecs[i].wa; rsa = vecs[i].rsa; rta = vecs[i].rta;
            #2;
            if (vecs[i].rw) check($sformatf("v%0d_wbdata", i), wb_d, vecs[i].exp_wb);
            check($sformatf("v%0d_valid", i), wb_v, vecs[i].exp_valid);
            check($sformatf("v%0d_rs", i), rs_d, vecs[i].exp_rs);
            check($sformatf("v%0d_rt", i), rt_d, vecs[i].exp_rt);
            tick();
            check($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
        end
        exp_cnt = 5;
        m2r = 1'b0;

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 10; i++) write_reg(5'd3, 32'(i));
        check("cnt_15", cnt, 32'(exp_cnt));
        check("cnt_small_15", cnt_s, 4'hF);
        write_reg(5'd3, 32'hCAFE);
        check("cnt_16", cnt, 32'(exp_cnt));
        check("cnt_small_wrap", cnt_s, 4'h0);
        for (int i = 0; i < 15; i++) write_reg(5'd3, 32'h100 + 32'(i));
        check("cnt_31", cnt, 32'(exp_cnt));
        check("cnt_small_ones", cnt_s, 4'hF);

        // Reset with a concurrent write to reg3: bypass suppressed, write lost.
        rw = 1'b1; wa = 5'd3; alu = 32'hBEEF; rsa = 5'd3; rta = 5'd3;
        rst = 1'b0;
        #2;
        check("rst_no_bypass", rs_d, 32'h10E);
        tick();
        check("rst_cnt", cnt, 0);
        check("rst_cnt_small", cnt_s, 0);
        check("rst_reg3", rs_d, 0);
        rw = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_reg3", rt_d, 0);
        check("post_rst_cnt", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
